// File: rtl/fare_pkg.sv
// Shared definitions for the fare lookup / RAM arbitration slice.
//   - line base and line size constants of the fare table
//   - station stride used to form the fare-table address
//   - lookup FSM state encoding
//   - read-tag encoding carried through the RAM latency pipe
package fare_pkg;

    localparam logic [6:0] LINE0_BASE = 7'd0;
    localparam logic [6:0] LINE1_BASE = 7'd27;
    localparam logic [6:0] LINE2_BASE = 7'd53;
    localparam logic [6:0] LINE3_BASE = 7'd82;

    localparam logic [4:0] LINE0_SIZE = 5'd27;
    localparam logic [4:0] LINE1_SIZE = 5'd26;
    localparam logic [4:0] LINE2_SIZE = 5'd29;
    localparam logic [4:0] LINE3_SIZE = 5'd18;

    localparam int STN_STRIDE = 100;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CALC  = 3'd1,
        ST_GRANT = 3'd2,
        ST_WAIT  = 3'd3,
        ST_ACK   = 3'd4,
        ST_HOLD  = 3'd5
    } fare_state_t;

    // Owner of a RAM read in flight.
    typedef enum logic [1:0] {
        TAG_NONE = 2'b00,
        TAG_DISP = 2'b01,
        TAG_FARE = 2'b10
    } tag_t;

    function automatic logic [6:0] line_base(input logic [1:0] line);
        case (line)
            2'd0:    return LINE0_BASE;
            2'd1:    return LINE1_BASE;
            2'd2:    return LINE2_BASE;
            default: return LINE3_BASE;
        endcase
    endfunction

    function automatic logic [4:0] line_size(input logic [1:0] line);
        case (line)
            2'd0:    return LINE0_SIZE;
            2'd1:    return LINE1_SIZE;
            2'd2:    return LINE2_SIZE;
            default: return LINE3_SIZE;
        endcase
    endfunction

endpackage

// File: rtl/fare_addr_calc.sv
// Fare-table address calculator, one cycle of latency.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   startline/startpoint     start line code and station within line
//   endline/endpoint         end line code and station within line
//   addr                     start_index*STN_STRIDE + end_index (registered)
//   err                      a station lies outside its line (registered)
module fare_addr_calc
    import fare_pkg::*;
#(
    parameter int AW = 19
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    startline,
    input  logic [4:0]    startpoint,
    input  logic [1:0]    endline,
    input  logic [4:0]    endpoint,
    output logic [AW-1:0] addr,
    output logic          err
);

    logic [6:0]    start_idx_s;
    logic [6:0]    end_idx_s;
    logic [AW-1:0] addr_s;
    logic          err_s;
    logic [AW-1:0] addr_r;
    logic          err_r;

    // Global station indexes, table address and range check.
    always_comb begin
        start_idx_s = line_base(startline) + {2'b00, startpoint};
        end_idx_s   = line_base(endline) + {2'b00, endpoint};
        addr_s      = AW'(start_idx_s) * AW'(STN_STRIDE) + AW'(end_idx_s);
        err_s       = (startpoint >= line_size(startline)) ||
                      (endpoint >= line_size(endline));
    end

    // Result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r <= {AW{1'b0}};
            err_r  <= 1'b0;
        end else begin
            addr_r <= addr_s;
            err_r  <= err_s;
        end
    end

    assign addr = addr_r;
    assign err  = err_r;

endmodule

// File: rtl/fare_ram_arbiter.sv
// Fare lookup sequencer and read-port arbiter for the fare/display block RAM.
// Display reads win each cycle unless a waiting fare has already seen
// MAX_WAIT consecutive display grants. A tag pipe RD_LAT deep routes the
// returning RAM data to the display or to the fare price register.
// Optional build macro: FARE_CACHE_EN adds a one-entry cache of the last
// successful lookup; a hit acks two cycles after the request without RAM access.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   fare_req + four codes       fare request (held until fare_ack)
//   fare_ack, price, fare_err   one-cycle ack; price/err held until next ack
//   disp_rd, disp_addr          display read request (held while denied)
//   disp_gnt                    display accepted this cycle (combinational)
//   disp_valid, disp_data       display read return
//   ram_addr, ram_dout          RAM read port
module fare_ram_arbiter
    import fare_pkg::*;
#(
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 8,
    parameter int AW       = 19,
    parameter int DW       = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fare_req,
    input  logic [1:0]    startline,
    input  logic [4:0]    startpoint,
    input  logic [1:0]    endline,
    input  logic [4:0]    endpoint,
    output logic          fare_ack,
    output logic [3:0]    price,
    output logic          fare_err,
    input  logic          disp_rd,
    input  logic [AW-1:0] disp_addr,
    output logic          disp_gnt,
    output logic          disp_valid,
    output logic [DW-1:0] disp_data,
    output logic [AW-1:0] ram_addr,
    input  logic [DW-1:0] ram_dout
);

    fare_state_t   state_r, state_s;
    logic [1:0]    sl_r, el_r;
    logic [4:0]    sp_r, ep_r;
    logic [AW-1:0] calc_addr_s;
    logic          calc_err_s;
    logic [7:0]    starve_r;
    logic [1:0]    wait_cnt_r;
    logic          disp_gnt_s, fare_win_s;
    logic [AW-1:0] ram_addr_s, ram_addr_r;
    tag_t          tag_s;
    tag_t          tag_pipe_r [RD_LAT];
    logic          fare_tag_out_s, disp_tag_out_s;
    logic          hit_s;
    logic [3:0]    hit_price_s;
    logic          fare_ack_r, fare_err_r;
    logic [3:0]    price_r;

    fare_addr_calc #(.AW(AW)) u_addr_calc (
        .clk        (clk),
        .rst        (rst),
        .startline  (sl_r),
        .startpoint (sp_r),
        .endline    (el_r),
        .endpoint   (ep_r),
        .addr       (calc_addr_s),
        .err        (calc_err_s)
    );

    assign fare_tag_out_s = (tag_pipe_r[RD_LAT-1] == TAG_FARE);
    assign disp_tag_out_s = (tag_pipe_r[RD_LAT-1] == TAG_DISP);

`ifdef FARE_CACHE_EN
    logic       cache_vld_r;
    logic [1:0] c_sl_r, c_el_r;
    logic [4:0] c_sp_r, c_ep_r;
    logic [3:0] c_price_r;

    // Hit when the latched codes match the last successful lookup.
    always_comb begin
        hit_s       = cache_vld_r &&
                      ({c_sl_r, c_sp_r, c_el_r, c_ep_r} == {sl_r, sp_r, el_r, ep_r});
        hit_price_s = c_price_r;
    end

    // Cache fill on every fare data return; errors never reach the RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            cache_vld_r <= 1'b0;
            c_sl_r      <= 2'd0;
            c_sp_r      <= 5'd0;
            c_el_r      <= 2'd0;
            c_ep_r      <= 5'd0;
            c_price_r   <= 4'd0;
        end else if (fare_tag_out_s) begin
            cache_vld_r <= 1'b1;
            c_sl_r      <= sl_r;
            c_sp_r      <= sp_r;
            c_el_r      <= el_r;
            c_ep_r      <= ep_r;
            c_price_r   <= ram_dout[3:0];
        end else begin
            cache_vld_r <= cache_vld_r;
        end
    end
`else
    assign hit_s       = 1'b0;
    assign hit_price_s = 4'd0;
`endif

    // Port arbitration: display first unless the fare has starved MAX_WAIT cycles.
    always_comb begin
        disp_gnt_s = 1'b0;
        fare_win_s = 1'b0;
        tag_s      = TAG_NONE;
        ram_addr_s = ram_addr_r;
        if (!rst && disp_rd && (starve_r < 8'(MAX_WAIT))) begin
            disp_gnt_s = 1'b1;
            tag_s      = TAG_DISP;
            ram_addr_s = disp_addr;
        end else if (!rst && (state_r == ST_GRANT) && !calc_err_s) begin
            fare_win_s = 1'b1;
            tag_s      = TAG_FARE;
            ram_addr_s = calc_addr_s;
        end else begin
            tag_s      = TAG_NONE;
        end
    end

    // Next-state logic; the range check result is first visible in GRANT.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:  if (fare_req) state_s = ST_CALC; else state_s = ST_IDLE;
            ST_CALC:  if (hit_s) state_s = ST_ACK; else state_s = ST_GRANT;
            ST_GRANT: if (calc_err_s) state_s = ST_ACK;
                      else if (fare_win_s) state_s = ST_WAIT;
                      else state_s = ST_GRANT;
            ST_WAIT:  if (wait_cnt_r == 2'(RD_LAT - 1)) state_s = ST_ACK;
                      else state_s = ST_WAIT;
            ST_ACK:   state_s = ST_HOLD;
            ST_HOLD:  if (!fare_req) state_s = ST_IDLE; else state_s = ST_HOLD;
            default:  state_s = ST_IDLE;
        endcase
    end

    // FSM, code latch, starvation/latency counters and fare result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            sl_r       <= 2'd0;
            sp_r       <= 5'd0;
            el_r       <= 2'd0;
            ep_r       <= 5'd0;
            starve_r   <= 8'd0;
            wait_cnt_r <= 2'd0;
            ram_addr_r <= {AW{1'b0}};
            fare_ack_r <= 1'b0;
            price_r    <= 4'd0;
            fare_err_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            ram_addr_r <= ram_addr_s;
            fare_ack_r <= (state_s == ST_ACK);
            if ((state_r == ST_IDLE) && fare_req) begin
                sl_r <= startline;
                sp_r <= startpoint;
                el_r <= endline;
                ep_r <= endpoint;
            end
            if ((state_r != ST_GRANT) || fare_win_s) begin
                starve_r <= 8'd0;
            end else if (disp_gnt_s) begin
                starve_r <= starve_r + 8'd1;
            end
            if (state_r == ST_WAIT) begin
                wait_cnt_r <= wait_cnt_r + 2'd1;
            end else begin
                wait_cnt_r <= 2'd0;
            end
            if ((state_r == ST_GRANT) && calc_err_s) begin
                price_r    <= 4'd0;
                fare_err_r <= 1'b1;
            end else if (fare_tag_out_s) begin
                price_r    <= ram_dout[3:0];
                fare_err_r <= 1'b0;
            end else if ((state_r == ST_CALC) && hit_s) begin
                price_r    <= hit_price_s;
                fare_err_r <= 1'b0;
            end
        end
    end

    // Read-tag pipe aligned with the RAM read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) tag_pipe_r[i] <= TAG_NONE;
        end else begin
            tag_pipe_r[0] <= tag_s;
            for (int i = 1; i < RD_LAT; i++) tag_pipe_r[i] <= tag_pipe_r[i-1];
        end
    end

    assign disp_gnt   = disp_gnt_s;
    assign ram_addr   = ram_addr_s;
    assign disp_valid = disp_tag_out_s;
    assign disp_data  = disp_tag_out_s ? ram_dout : {DW{1'b0}};
    assign fare_ack   = fare_ack_r;
    assign price      = price_r;
    assign fare_err   = fare_err_r;

endmodule

// File: tb/tb_fare_ram_arbiter.sv
// Randomized bench for fare_ram_arbiter with a transaction-level reference:
// fare results come from the line tables, port ownership from a count of
// display grants since the fare became eligible, display returns from a
// queue of due cycles.
module tb_fare_ram_arbiter;

    localparam int RD_LAT   = 2;
    localparam int MAX_WAIT = 3;
    localparam int AW       = 19;
    localparam int DW       = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fare_req = 1'b0;
    logic [1:0]    startline = 2'd0, endline = 2'd0;
    logic [4:0]    startpoint = 5'd0, endpoint = 5'd0;
    logic          fare_ack, fare_err;
    logic [3:0]    price;
    logic          disp_rd = 1'b0;
    logic [AW-1:0] disp_addr = '0;
    logic          disp_gnt, disp_valid;
    logic [DW-1:0] disp_data;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_dout;

    fare_ram_arbiter #(.RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .fare_req(fare_req),
        .startline(startline), .startpoint(startpoint),
        .endline(endline), .endpoint(endpoint),
        .fare_ack(fare_ack), .price(price), .fare_err(fare_err),
        .disp_rd(disp_rd), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
        .disp_valid(disp_valid), .disp_data(disp_data),
        .ram_addr(ram_addr), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // RAM contents: a fixed function of the address.
    function automatic logic [DW-1:0] ram_fn(input logic [AW-1:0] a);
        logic [31:0] t;
        if (a == 19'd3058) return 12'h00A;
        t = 32'(a) * 32'd13 + 32'd7;
        return t[11:0] ^ 12'h3C5;
    endfunction

    // RAM model with RD_LAT cycles of read latency.
    logic [AW-1:0] ram_pipe [RD_LAT];
    always @(posedge clk) begin
        ram_pipe[0] <= ram_addr;
        for (int i = 1; i < RD_LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
    end
    assign ram_dout = ram_fn(ram_pipe[RD_LAT-1]);

    int base_tbl [4] = '{0, 27, 53, 82};
    int size_tbl [4] = '{27, 26, 29, 18};

    typedef struct { int due; logic [DW-1:0] data; } dexp_t;
    dexp_t         dq [$];
    int            n_total = 0, n_bad = 0, cyc = 0;
    logic [AW-1:0] last_addr = '0;
    bit            prev_denied = 1'b0;
    int            disp_pct = 0;
    bit            disp_fix = 1'b0;
    logic [AW-1:0] disp_fix_addr = '0;
    logic [3:0]    held_price = 4'd0;
    bit            held_err = 1'b0;
    bit            c_vld = 1'b0;
    logic [13:0]   c_codes = '0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // New display request unless the previous one was denied (then it is held).
    task automatic drive_disp();
        if (!prev_denied) begin
            disp_rd   = (int'($urandom_range(0, 99)) < disp_pct);
            disp_addr = disp_fix ? disp_fix_addr : AW'($urandom_range(0, (1 << AW) - 1));
        end
    endtask

    // Port checks for the current cycle, sampled at the falling edge.
    task automatic sample(input bit gnt_e, input bit fwin, input logic [AW-1:0] faddr);
        bit    v_e;
        dexp_t e;
        @(negedge clk);
        check_val("disp_gnt", disp_gnt, gnt_e);
        v_e = (dq.size() > 0) && (dq[0].due == cyc);
        check_val("disp_valid", disp_valid, v_e);
        if (v_e) begin
            e = dq.pop_front();
            check_val("disp_data", disp_data, e.data);
        end
        if (gnt_e) begin
            last_addr = disp_addr;
            e.due = cyc + RD_LAT;
            e.data = ram_fn(disp_addr);
            dq.push_back(e);
        end else if (fwin) begin
            last_addr = faddr;
        end
        check_val("ram_addr", ram_addr, last_addr);
        prev_denied = disp_rd && !gnt_e;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive_disp();
            sample(disp_rd, 1'b0, '0);
            check_val("ack_idle", fare_ack, 1'b0);
            check_val("price_held", price, held_price);
            check_val("err_held", fare_err, held_err);
            advance();
        end
    endtask

    task automatic fare_txn(input logic [1:0] sl, input logic [4:0] sp,
                            input logic [1:0] el, input logic [4:0] ep);
        int            si, ei, c, waits, ack_at;
        bit            err_e, hit_e, won, done, elig, gnt_e, fwin;
        logic [AW-1:0] addr_e;
        logic [DW-1:0] word_e;
        logic [3:0]    price_e;
        si     = base_tbl[sl] + int'(sp);
        ei     = base_tbl[el] + int'(ep);
        err_e  = (int'(sp) >= size_tbl[sl]) || (int'(ep) >= size_tbl[el]);
        addr_e = AW'(si * 100 + ei);
        word_e = ram_fn(addr_e);
        price_e = err_e ? 4'd0 : word_e[3:0];
        hit_e  = 1'b0;
`ifdef FARE_CACHE_EN
        hit_e  = c_vld && !err_e && (c_codes == {sl, sp, el, ep});
`endif
        ack_at = err_e ? 3 : (hit_e ? 2 : -1);
        fare_req = 1'b1;
        startline = sl; startpoint = sp; endline = el; endpoint = ep;
        c = 0; waits = 0; won = 1'b0; done = 1'b0;
        while (!done && c < 64) begin
            if (c > 0) begin
                startline  = 2'($urandom);
                startpoint = 5'($urandom);
                endline    = 2'($urandom);
                endpoint   = 5'($urandom);
            end
            drive_disp();
            elig  = !err_e && !hit_e && !won && (c >= 2);
            gnt_e = disp_rd && (!elig || waits < MAX_WAIT);
            fwin  = elig && !gnt_e;
            if (elig && gnt_e) waits++;
            if (fwin) begin
                won = 1'b1;
                ack_at = c + 1 + RD_LAT;
            end
            sample(gnt_e, fwin, addr_e);
            check_val("fare_ack", fare_ack, (c == ack_at));
            if (c == ack_at) begin
                check_val("price", price, price_e);
                check_val("fare_err", fare_err, err_e);
                held_price = price_e;
                held_err   = err_e;
                done = 1'b1;
            end else begin
                check_val("price_held", price, held_price);
                check_val("err_held", fare_err, held_err);
            end
            advance();
            c++;
        end
        if (!done) check_val("ack_timeout", 32'd0, 32'd1);
        fare_req = 1'b0;
        if (!err_e) begin
            c_vld   = 1'b1;
            c_codes = {sl, sp, el, ep};
        end
    endtask

    task automatic model_reset();
        dq.delete();
        last_addr   = '0;
        prev_denied = 1'b0;
        held_price  = 4'd0;
        held_err    = 1'b0;
        c_vld       = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [1:0] sl, el;
        logic [4:0] sp, ep;
        #1;
        repeat (3) advance();
        rst = 1'b0;
        model_reset();
        // Quiet outputs after reset.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("rst_ack", fare_ack, 1'b0);
            check_val("rst_price", price, 4'd0);
            check_val("rst_err", fare_err, 1'b0);
            check_val("rst_gnt", disp_gnt, 1'b0);
            check_val("rst_valid", disp_valid, 1'b0);
            check_val("rst_data", disp_data, '0);
            check_val("rst_addr", ram_addr, '0);
            advance();
        end

        // Uncontended lookup, then an out-of-range station.
        disp_pct = 0;
        fare_txn(2'd1, 5'd3, 2'd2, 5'd5);
        idle(2);
        fare_txn(2'd3, 5'd18, 2'd0, 5'd0);
        idle(2);

        // Display requesting every cycle at a fixed address while a fare waits.
        disp_fix = 1'b1; disp_fix_addr = 19'd10000; disp_pct = 100;
        fare_txn(2'd0, 5'd5, 2'd3, 5'd2);
        idle(3);
        disp_fix = 1'b0; disp_pct = 0;
        idle(RD_LAT + 2);

        // Reset while waiting on the RAM, with a display read in flight.
        fare_req = 1'b1;
        startline = 2'd1; startpoint = 5'd3; endline = 2'd2; endpoint = 5'd5;
        for (int c = 0; c < 3; c++) begin
            disp_rd = 1'b0;
            sample(1'b0, (c == 2), 19'd3058);
            check_val("rw_ack", fare_ack, 1'b0);
            advance();
        end
        disp_rd = 1'b1; disp_addr = 19'd777;
        sample(1'b1, 1'b0, '0);
        check_val("rw_ack", fare_ack, 1'b0);
        advance();
        rst = 1'b1; fare_req = 1'b0; disp_rd = 1'b0;
        sample(1'b0, 1'b0, '0);
        check_val("rw_ack", fare_ack, 1'b0);
        advance();
        rst = 1'b0;
        model_reset();
        idle(4);

        // Repeated lookup (cache hit when the cache is built in).
        fare_txn(2'd1, 5'd3, 2'd2, 5'd5);
        idle(1);
        fare_txn(2'd1, 5'd3, 2'd2, 5'd5);
        idle(2);

        // Random fares under random display load.
        for (int n = 0; n < 40; n++) begin
            disp_pct = int'($urandom_range(0, 70));
            if (n == 0 || ($urandom_range(0, 3) != 0)) begin
                sl = 2'($urandom); sp = 5'($urandom);
                el = 2'($urandom); ep = 5'($urandom);
            end
            fare_txn(sl, sp, el, ep);
            idle(1 + int'($urandom_range(0, 2)));
        end
        disp_pct = 0;
        idle(RD_LAT + 2);
        check_val("disp_drain", dq.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
